// File: rtl/title_seq_ctrl.sv
// Title-screen overlay sequencer: typewriter reveal, blink until start key, fade out, then gameplay.
// Latency: all outputs registered, change on the edge that samples the cause; backpressure: none.
module title_seq_ctrl #(
  parameter int NUM_CHARS    = 7,
  parameter int CHAR_FRAMES  = 8,
  parameter int BLINK_FRAMES = 30,
  parameter int EXIT_FRAMES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 key_start,
  input  logic                 game_over,
  output logic [2:0]           state,
  output logic                 title_en,
  output logic [NUM_CHARS-1:0] char_mask,
  output logic                 blink_on,
  output logic [3:0]           fade_level,
  output logic                 game_start,
  output logic                 in_play
);

  localparam logic [2:0] REVEAL = 3'd0;
  localparam logic [2:0] HOLD   = 3'd1;
  localparam logic [2:0] EXIT   = 3'd2;
  localparam logic [2:0] PLAY   = 3'd3;

  localparam logic [7:0] CHAR_LAST  = 8'(CHAR_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] EXIT_LAST  = 8'(EXIT_FRAMES - 1);
  localparam logic [7:0] LAST_CHAR  = 8'(NUM_CHARS - 1);

  logic                 key_q;
  logic [7:0]           frame_cnt;
  logic [7:0]           char_cnt;
  logic                 key_edge;
  logic                 restart;
  logic [NUM_CHARS-1:0] char_bit;

  always_comb begin
    key_edge = key_start & ~key_q;
    // game_over only matters in PLAY; an illegal encoding recovers the same way
    restart  = ((state == PLAY) && game_over) || (state > PLAY);
    char_bit = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      char_bit[i] = (char_cnt == 8'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REVEAL;
      title_en   <= 1'b1;
      char_mask  <= '0;
      blink_on   <= 1'b1;
      fade_level <= 4'd15;
      game_start <= 1'b0;
      in_play    <= 1'b0;
      frame_cnt  <= 8'd0;
      char_cnt   <= 8'd0;
      // starting high means a key held through reset needs a release first
      key_q      <= 1'b1;
    end else begin
      key_q      <= key_start;
      game_start <= 1'b0;
      if (restart) begin
        state      <= REVEAL;
        title_en   <= 1'b1;
        char_mask  <= '0;
        blink_on   <= 1'b1;
        fade_level <= 4'd15;
        in_play    <= 1'b0;
        frame_cnt  <= 8'd0;
        char_cnt   <= 8'd0;
      end else begin
        case (state)
          REVEAL: begin
            if (key_edge) begin
              char_mask <= '1;
              state     <= HOLD;
              frame_cnt <= 8'd0;
            end else if (frame_tick) begin
              if (frame_cnt == CHAR_LAST) begin
                frame_cnt <= 8'd0;
                char_mask <= char_mask | char_bit;
                char_cnt  <= char_cnt + 8'd1;
                if (char_cnt == LAST_CHAR) begin
                  state <= HOLD;
                end
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          HOLD: begin
            if (key_edge) begin
              state     <= EXIT;
              blink_on  <= 1'b1;
              frame_cnt <= 8'd0;
            end else if (frame_tick) begin
              if (frame_cnt == BLINK_LAST) begin
                frame_cnt <= 8'd0;
                blink_on  <= ~blink_on;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          EXIT: begin
            if (frame_tick) begin
              if (frame_cnt == EXIT_LAST) begin
                frame_cnt <= 8'd0;
                // the period after reaching black hands over instead of wrapping
                if (fade_level == 4'd0) begin
                  state      <= PLAY;
                  title_en   <= 1'b0;
                  in_play    <= 1'b1;
                  game_start <= 1'b1;
                end else begin
                  fade_level <= fade_level - 4'd1;
                end
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
